// File: rtl/rock_search_ctrl.sv
// Hill-climbing rocking controller: averages cry volume + heart rate, steps A/F and keeps or reverts each step.
// Optional calm-stop behaviour is enabled by defining ROCK_CALM_STOP_EN.
module rock_search_ctrl #(
  parameter int SENS_W     = 8,
  parameter int LVL_W      = 4,
  parameter int A_START    = 4,
  parameter int F_START    = 4,
  parameter int AVG_LOG2   = 3,
  parameter int SETTLE_CYC = 1024,
  parameter int HYST       = 2,
  parameter int HOLD_CYC   = 65536,
  parameter int CALM_THR   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sampleValid,
  input  logic [SENS_W-1:0] huilVolume,
  input  logic [SENS_W-1:0] hartRitme,
  output logic [LVL_W-1:0]  A,
  output logic [LVL_W-1:0]  F,
  output logic              stressGezakt,
  output logic              locked,
  output logic [2:0]        state
);

  localparam logic [2:0] BASE   = 3'd0;
  localparam logic [2:0] STEP   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] MEAS   = 3'd3;
  localparam logic [2:0] DECIDE = 3'd4;
  localparam logic [2:0] HOLD   = 3'd5;
  localparam logic [2:0] CALM   = 3'd6;

  localparam logic [1:0] DIR_AP = 2'd0;
  localparam logic [1:0] DIR_AM = 2'd1;
  localparam logic [1:0] DIR_FP = 2'd2;

  localparam int AVG_W = SENS_W + 1;
  localparam int ACC_W = SENS_W + 1 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [LVL_W-1:0] LVL_MAX     = '1;

  logic [2:0]       stateReg;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] sampleCnt;
  logic [31:0]      cycCnt;
  logic [AVG_W-1:0] best;
  logic [AVG_W-1:0] measAvg;
  logic [LVL_W-1:0] prevA;
  logic [LVL_W-1:0] prevF;
  logic [1:0]       dir;
  logic [2:0]       fails;

  logic [AVG_W-1:0] sample;
  logic [ACC_W-1:0] accSum;
  logic [AVG_W-1:0] winAvg;
  logic             winDone;
  logic             saturated;
  logic             improved;
  logic [2:0]       failsInc;

  assign sample   = AVG_W'(huilVolume) + AVG_W'(hartRitme);
  assign accSum   = acc + ACC_W'(sample);
  assign winAvg   = accSum[ACC_W-1:AVG_LOG2];
  assign winDone  = sampleValid && (sampleCnt == LAST_SAMPLE);
  assign improved = (32'(measAvg) + 32'(HYST)) <= 32'(best);
  assign failsInc = fails + 3'd1;

  assign state  = stateReg;
  assign locked = (stateReg == HOLD) || (stateReg == CALM);

`ifdef ROCK_CALM_STOP_EN
  logic calmLow;
  logic calmHigh;
  assign calmLow  = 32'(winAvg) <= 32'(CALM_THR);
  assign calmHigh = 32'(winAvg) > (32'(CALM_THR) + 32'(HYST));
`endif

  always_comb begin
    saturated = 1'b0;
    case (dir)
      DIR_AP:  saturated = (A == LVL_MAX);
      DIR_AM:  saturated = (A == '0);
      DIR_FP:  saturated = (F == LVL_MAX);
      default: saturated = (F == '0);
    endcase
  end

  // Window accumulation is shared by BASE, MEAS and CALM; the final sample is folded in via accSum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg     <= BASE;
      A            <= LVL_W'(A_START);
      F            <= LVL_W'(F_START);
      stressGezakt <= 1'b0;
      acc          <= '0;
      sampleCnt    <= '0;
      cycCnt       <= '0;
      best         <= '0;
      measAvg      <= '0;
      prevA        <= LVL_W'(A_START);
      prevF        <= LVL_W'(F_START);
      dir          <= DIR_AP;
      fails        <= '0;
    end else begin
      stressGezakt <= 1'b0;
      if ((stateReg == BASE || stateReg == MEAS || stateReg == CALM) && sampleValid) begin
        if (winDone) begin
          acc       <= '0;
          sampleCnt <= '0;
        end else begin
          acc       <= accSum;
          sampleCnt <= sampleCnt + 1'b1;
        end
      end
      case (stateReg)
        BASE: begin
          if (winDone) begin
            best  <= winAvg;
            dir   <= DIR_AP;
            fails <= '0;
`ifdef ROCK_CALM_STOP_EN
            if (calmLow) begin
              A        <= '0;
              F        <= '0;
              stateReg <= CALM;
            end else
`endif
            stateReg <= STEP;
          end
        end
        STEP: begin
          prevA <= A;
          prevF <= F;
          if (saturated) begin
            fails <= failsInc;
            dir   <= dir + 2'd1;
            if (failsInc == 3'd4) begin
              cycCnt   <= '0;
              stateReg <= HOLD;
            end
          end else begin
            case (dir)
              DIR_AP:  A <= A + 1'b1;
              DIR_AM:  A <= A - 1'b1;
              DIR_FP:  F <= F + 1'b1;
              default: F <= F - 1'b1;
            endcase
            cycCnt   <= '0;
            stateReg <= SETTLE;
          end
        end
        SETTLE: begin
          if (cycCnt == 32'(SETTLE_CYC - 1)) begin
            cycCnt   <= '0;
            stateReg <= MEAS;
          end else begin
            cycCnt <= cycCnt + 32'd1;
          end
        end
        MEAS: begin
          if (winDone) begin
            measAvg <= winAvg;
`ifdef ROCK_CALM_STOP_EN
            if (calmLow) begin
              A        <= '0;
              F        <= '0;
              stateReg <= CALM;
            end else
`endif
            stateReg <= DECIDE;
          end
        end
        DECIDE: begin
          cycCnt <= '0;
          // A zero average cannot be beaten, so searching further is pointless.
          if (improved) begin
            best         <= measAvg;
            stressGezakt <= 1'b1;
            fails        <= '0;
            stateReg     <= (measAvg == '0) ? HOLD : STEP;
          end else begin
            A        <= prevA;
            F        <= prevF;
            fails    <= failsInc;
            dir      <= dir + 2'd1;
            stateReg <= (failsInc == 3'd4 || measAvg == '0) ? HOLD : STEP;
          end
        end
        HOLD: begin
          if (cycCnt == 32'(HOLD_CYC - 1)) begin
            cycCnt   <= '0;
            stateReg <= BASE;
          end else begin
            cycCnt <= cycCnt + 32'd1;
          end
        end
`ifdef ROCK_CALM_STOP_EN
        CALM: begin
          if (winDone && calmHigh) begin
            A        <= LVL_W'(A_START);
            F        <= LVL_W'(F_START);
            stateReg <= BASE;
          end
        end
`else
        CALM: stateReg <= BASE;
`endif
        default: stateReg <= BASE;
      endcase
    end
  end

endmodule

// File: doc/rock_search_ctrl.md
# rock_search_ctrl

Parametrised successor of the rocking controller: one module that merges stress measurement, search and amplitude/frequency output into a single hill-climbing FSM. It averages cry volume plus heart rate over a configurable window, waits for the cradle to settle after each setting change, and keeps or reverts each A/F step depending on whether averaged stress dropped. It sits between the sensor front-end and the motor driver, replacing the separate stress/pathfinding/generator chain.

## Interface
- SENS_W, 8, sensor sample width
- LVL_W, 4, width of A and F level outputs
- A_START, 4, A after reset (≤ 2^LVL_W−1)
- F_START, 4, F after reset
- AVG_LOG2, 3, log2 of samples per measurement window
- SETTLE_CYC, 1024, clk cycles waited after a step before measuring (≥1)
- HYST, 2, minimum avg-stress drop for a step to count as improvement
- HOLD_CYC, 65536, cycles spent in HOLD before re-baselining
- CALM_THR, 8, calm threshold (used only with ROCK_CALM_STOP_EN)

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- sampleValid  in  1  huilVolume/hartRitme valid this cycle
- huilVolume  in  SENS_W  cry volume sample
- hartRitme  in  SENS_W  heart-rate sample
- A  out  LVL_W  amplitude level, registered
- F  out  LVL_W  frequency level, registered
- stressGezakt  out  1  one-cycle pulse when a step is accepted
- locked  out  1  high while in HOLD
- state  out  3  FSM state code for debug

## Operation
- Stress sample s = huilVolume + hartRitme, SENS_W+1 bits, no overflow. Accumulator SENS_W+1+AVG_LOG2 bits; avg = acc >> AVG_LOG2. Only cycles with sampleValid=1 count.
- States (codes): BASE=0, STEP=1, SETTLE=2, MEAS=3, DECIDE=4, HOLD=5, CALM=6.
- BASE: collect 2^AVG_LOG2 samples → best = avg, dir = A+, fails = 0, → STEP.
- STEP (1 cycle): save prevA/prevF; apply dir (A+1, A−1, F+1, F−1). If the move would leave [0, 2^LVL_W−1], no change, count as failure, advance dir, stay in STEP (next cycle). Otherwise → SETTLE.
- SETTLE: count SETTLE_CYC cycles; samples ignored. → MEAS.
- MEAS: collect 2^AVG_LOG2 samples → DECIDE.
- DECIDE (1 cycle): if avg + HYST ≤ best: accept, best = avg, stressGezakt = 1, fails = 0, keep dir. Else revert A/F to prev, fails+1, dir advances (A+→A−→F+→F−→A+). → STEP, unless fails = 4 → HOLD.
- HOLD: A/F frozen, locked = 1, count HOLD_CYC → BASE.
- avg = 0 at any DECIDE is accepted (if HYST permits) and forces HOLD next.
- Outputs only change in STEP/DECIDE/CALM entry; never mid-SETTLE/MEAS.

## Timing
- Reset (reset=0 at clk edge): A=A_START, F=F_START, stressGezakt=0, locked=0, state=BASE, acc=0, counters=0, fails=0, dir=A+. Reset mid-operation aborts any window immediately; partial accumulations discarded.
- A/F change visible the cycle after STEP or DECIDE.
- stressGezakt asserted exactly the cycle after DECIDE evaluation, one cycle wide.
- Minimum step turnaround with sampleValid held high: 1 (STEP) + SETTLE_CYC + 2^AVG_LOG2 + 1 (DECIDE) cycles.
- sampleValid low stalls MEAS/BASE indefinitely; SETTLE/HOLD counters run regardless.
- Four consecutive saturated moves pass through STEP in 4 cycles and enter HOLD.

## Configuration
- ROCK_CALM_STOP_EN defined: at end of any BASE or MEAS window, avg ≤ CALM_THR → CALM: A=0, F=0, locked=1; windows keep being measured; avg > CALM_THR+HYST → A=A_START, F=F_START, → BASE.
- Undefined: CALM state unreachable, CALM_THR ignored, no zero-forcing of A/F.

## Test plan
- Use SENS_W=8, LVL_W=4, AVG_LOG2=1, SETTLE_CYC=4, HYST=2, HOLD_CYC=16.
- Reset release, constant 50+50, sampleValid=1 → A=4,F=4 after reset; BASE best=100; A+ step to 5, no improvement → revert to 4, all four directions fail → locked=1 after 4 DECIDEs, HOLD 16 cycles, back to BASE.
- Stress falls by 10 per accepted A+ step → A climbs 4→5→6…, stressGezakt pulse each accept, dir stays A+.
- A_START=15 → first A+ saturates, no SETTLE entered, next cycle tries A−.
- sampleValid toggled every other cycle in MEAS → window completes after 2 valid samples only; avg matches.
- reset=0 asserted mid-SETTLE → next cycle A=A_START, F=F_START, state=BASE, stressGezakt=0.
- ROCK_CALM_STOP_EN, CALM_THR=8, input 2+2 → A=F=0, state=6; raise to 20+20 → A=4,F=4, state=0.
